// File: rtl/addr_calc_pipe.sv
// Pipelined pointer-relative address calculator with valid/ready flow control.
// Stage 1 holds every channel's result; stage 2 holds the late-selected one.
module addr_calc_pipe #(
  parameter int AW   = 8,
  parameter int OW   = 16,
  parameter int NPTR = 2,
  parameter int BASE = 128,
  localparam int SW  = $clog2(NPTR)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        address,
  input  logic [NPTR*AW-1:0]   ptr,
  input  logic [AW-1:0]        b,
  input  logic [SW-1:0]        sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OW-1:0]        count,
  output logic                 wrap
);

  localparam logic [AW-1:0] BASE_V = AW'(BASE);
  localparam logic [SW:0]   NPTR_V = (SW+1)'(NPTR);

  logic [NPTR-1:0][AW-1:0] calc_offset;
  logic [NPTR-1:0][OW-1:0] calc_count;
  logic [NPTR-1:0]         calc_wrap;

  logic                    s1_valid;
  logic [NPTR-1:0][OW-1:0] s1_count;
  logic [NPTR-1:0]         s1_wrap;
  logic [SW-1:0]           s1_sel;

  logic [SW-1:0]           sel_idx;
  logic [OW-1:0]           mux_count;
  logic                    mux_wrap;

  logic                    s2_en;
  logic                    s1_en;
  logic                    in_xfer;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en && rst_n;
  assign in_xfer  = in_valid && s1_en;

  // Per-channel offset, count and wrap; the select mux is deferred to stage 2.
  always_comb begin
    calc_offset = '0;
    calc_count  = '0;
    calc_wrap   = '0;
    for (int i = 0; i < NPTR; i++) begin
      calc_offset[i] = BASE_V - ptr[i*AW +: AW];
      calc_count[i]  = {{(OW-AW){1'b0}}, address}
                     - {{(OW-AW){1'b0}}, calc_offset[i]}
                     + {{(OW-AW){1'b0}}, b};
      calc_wrap[i]   = ({1'b0, address} + {1'b0, b}) < {1'b0, calc_offset[i]};
    end
  end

  // Out-of-range selects (non-power-of-2 NPTR) fall back to channel 0.
  always_comb begin
    sel_idx   = {SW{1'b0}};
    mux_count = '0;
    mux_wrap  = 1'b0;
    if ({1'b0, s1_sel} < NPTR_V) begin
      sel_idx = s1_sel;
    end else begin
      sel_idx = {SW{1'b0}};
    end
    mux_count = s1_count[sel_idx];
    mux_wrap  = s1_wrap[sel_idx];
  end

  // Stage 1 valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
    end
  end

  // Stage 1 data loads only on an accepted input, so no reset is needed.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_count <= calc_count;
      s1_wrap  <= calc_wrap;
      s1_sel   <= sel;
    end
  end

  // Stage 2 output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      count     <= '0;
      wrap      <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        count <= mux_count;
        wrap  <= mux_wrap;
      end
    end
  end

endmodule

// File: tb/tb_addr_calc_pipe.sv
// Directed bench for addr_calc_pipe: vector table plus reset, stall and
// NPTR=3 sequences. Inputs change #1 after posedge and outputs are sampled there.
module tb_addr_calc_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, wrap;
  logic [7:0]  address, b;
  logic [15:0] ptr;
  logic [0:0]  sel;
  logic [15:0] count;

  logic        in_valid3, in_ready3, out_valid3, out_ready3, wrap3;
  logic [7:0]  address3, b3;
  logic [23:0] ptr3;
  logic [1:0]  sel3;
  logic [15:0] count3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  address;
    logic [7:0]  ptr0;
    logic [7:0]  ptr1;
    logic [7:0]  b;
    logic        sel;
    logic [15:0] count;
    logic        wrap;
  } vec_t;

  vec_t vecs[8];
  logic [16:0] exp_q[$];

  addr_calc_pipe #(.AW(8), .OW(16), .NPTR(2), .BASE(128)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .address(address), .ptr(ptr), .b(b), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .count(count), .wrap(wrap)
  );

  addr_calc_pipe #(.AW(8), .OW(16), .NPTR(3), .BASE(128)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .address(address3), .ptr(ptr3), .b(b3), .sel(sel3),
    .out_valid(out_valid3), .out_ready(out_ready3), .count(count3), .wrap(wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signed-integer reference: negative true result means wrap.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] p,
                                        input logic [7:0] bb);
    int off;
    int t;
    logic [31:0] tv;
    off = (128 - int'(p)) & 255;
    t   = int'(a) - off + int'(bb);
    tv  = t;
    return {(t < 0) ? 1'b1 : 1'b0, tv[15:0]};
  endfunction

  initial begin
    int idx;
    int got;
    logic acc_in, acc_out, prev_stall, saw_low;
    logic [15:0] prev_count;
    logic prev_wrap;
    logic [16:0] e;

    vecs[0] = '{8'h10, 8'h20, 8'h00, 8'h05, 1'b0, 16'hFFB5, 1'b1};
    vecs[1] = '{8'h10, 8'h20, 8'h7F, 8'h05, 1'b1, 16'h0014, 1'b0};
    vecs[2] = '{8'h10, 8'h20, 8'h80, 8'h05, 1'b1, 16'h0015, 1'b0};
    vecs[3] = '{8'hFF, 8'h81, 8'h00, 8'hFF, 1'b0, 16'h00FF, 1'b0};
    vecs[4] = '{8'h00, 8'h55, 8'h00, 8'h00, 1'b1, 16'hFF80, 1'b1};
    vecs[5] = '{8'h20, 8'h40, 8'h11, 8'h20, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{8'h1F, 8'h40, 8'h22, 8'h20, 1'b0, 16'hFFFF, 1'b1};
    vecs[7] = '{8'hFF, 8'h33, 8'h01, 8'hFF, 1'b1, 16'h017F, 1'b0};

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    address = 8'h00; ptr = 16'h0000; b = 8'h00; sel = 1'b0;
    in_valid3 = 1'b0; out_ready3 = 1'b1;
    address3 = 8'h00; ptr3 = 24'h000000; b3 = 8'h00; sel3 = 2'd0;

    // Reset held 3 cycles with in_valid high
    repeat (3) tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {16'd0, count}, 32'd0);
    check("rst_wrap", {31'd0, wrap}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);

    // Table vectors: single transfer, result visible after the second edge
    for (int v = 0; v < 8; v++) begin
      address = vecs[v].address; ptr = {vecs[v].ptr1, vecs[v].ptr0};
      b = vecs[v].b; sel = vecs[v].sel; in_valid = 1'b1;
      #1;
      check($sformatf("v%0d_in_ready", v), {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      address = 8'hXX; ptr = 16'hXXXX; b = 8'hXX; sel = 1'bx;
      check($sformatf("v%0d_early_valid", v), {31'd0, out_valid}, 32'd0);
      tick();
      check($sformatf("v%0d_out_valid", v), {31'd0, out_valid}, 32'd1);
      check($sformatf("v%0d_count", v), {16'd0, count}, {16'd0, vecs[v].count});
      check($sformatf("v%0d_wrap", v), {31'd0, wrap}, {31'd0, vecs[v].wrap});
      tick();
      check($sformatf("v%0d_valid_drop", v), {31'd0, out_valid}, 32'd0);
    end

    // Streaming 8 inputs with out_ready low for cycles 3-6
    idx = 0; got = 0; prev_stall = 1'b0; saw_low = 1'b0;
    prev_count = 16'h0000; prev_wrap = 1'b0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      in_valid = (idx < 8);
      address = 8'(8 * idx + 1); ptr = {8'(8'h7F - idx), 8'(idx * 16)};
      b = 8'(idx); sel = 1'(idx);
      out_ready = !(c >= 3 && c <= 6);
      #1;
      if (prev_stall) begin
        check("stall_count_stable", {16'd0, count}, {16'd0, prev_count});
        check("stall_wrap_stable", {31'd0, wrap}, {31'd0, prev_wrap});
      end
      if (out_ready) check("ready_passthrough", {31'd0, in_ready}, 32'd1);
      if (!in_ready) saw_low = 1'b1;
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("stream_count%0d", got), {16'd0, count}, {16'd0, e[15:0]});
          check($sformatf("stream_wrap%0d", got), {31'd0, wrap}, {31'd0, e[16]});
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_count = count;
      prev_wrap  = wrap;
      if (acc_in) exp_q.push_back(model(address, sel ? ptr[15:8] : ptr[7:0], b));
      tick();
      if (acc_in) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_accepted", idx, 32'd8);
    check("stream_received", got, 32'd8);
    check("stream_in_ready_dropped", {31'd0, saw_low}, 32'd1);
    tick(); tick();
    check("stream_no_extra", {31'd0, out_valid}, 32'd0);

    // Mid-operation reset with both stages full and backpressure
    out_ready = 1'b0; in_valid = 1'b1;
    address = 8'h10; ptr = 16'h0020; b = 8'h05; sel = 1'b0;
    tick(); tick();
    in_valid = 1'b0;
    #1;
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_count", {16'd0, count}, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("midrst_no_stale%0d", k), {31'd0, out_valid}, 32'd0);
    end

    // NPTR=3 instance: out-of-range select falls back to channel 0
    address3 = 8'h00; b3 = 8'h00; ptr3 = {8'h7F, 8'h80, 8'h7E};
    for (int s = 3; s >= 1; s--) begin
      sel3 = 2'(s); in_valid3 = 1'b1;
      tick();
      in_valid3 = 1'b0;
      tick();
      check($sformatf("n3_sel%0d_valid", s), {31'd0, out_valid3}, 32'd1);
      check($sformatf("n3_sel%0d_count", s), {16'd0, count3},
            (s == 3) ? 32'h0000FFFE : (s == 2) ? 32'h0000FFFF : 32'h00000000);
      check($sformatf("n3_sel%0d_wrap", s), {31'd0, wrap3}, (s == 1) ? 32'd0 : 32'd1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
